// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - register bus bundle for the PWM capture block
interface pwm_capture_if;
  logic        bus_write_en;
  logic        bus_read_en;
  logic        capture_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;

  modport master (
    output bus_write_en, bus_read_en, capture_en, bus_addr, bus_write_data,
    input  bus_read_data
  );

  modport slave (
    input  bus_write_en, bus_read_en, capture_en, bus_addr, bus_write_data,
    output bus_read_data
  );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM input capture of high time and period; PWMCAP_FILTER_EN adds a glitch filter
module pwm_capture #(
  parameter int unsigned TIMEOUT    = 4000000,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic          pclk,
  input  logic          nreset,
  pwm_capture_if.slave  bus,
  input  logic          pwm_in,
  output logic          capture_valid
);

  typedef enum logic [1:0] {IDLE, HI, LO} state_e;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_HIGH   = 8'h08;
  localparam logic [7:0] ADDR_PERIOD = 8'h0C;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, lvl_q;
  logic        lvl;
  logic [31:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] hi_tmp_q, hi_tmp_d;
  logic [31:0] high_q, high_d;
  logic [31:0] period_q, period_d;
  logic        ctrl_q, ctrl_d;
  logic [2:0]  status_q, status_d;
  logic        set_valid, set_timeout, set_ovf;
  logic        rise, fall, wr, rd;
  logic        unused_wdata;

`ifdef PWMCAP_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = sync2_q;
      else fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  assign rise    = lvl & ~lvl_q;
  assign fall    = ~lvl & lvl_q;
  assign wr      = bus.bus_write_en & bus.capture_en;
  assign rd      = bus.bus_read_en & bus.capture_en;
  assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
  assign unused_wdata = ^bus.bus_write_data[31:3];

  // cnt_inc includes the current cycle, so captured values are exact cycle counts.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q == IDLE) ? 32'd0 : cnt_inc;
    hi_tmp_d    = hi_tmp_q;
    high_d      = high_q;
    period_d    = period_q;
    set_valid   = 1'b0;
    set_timeout = 1'b0;
    if (!ctrl_q) begin
      state_d = IDLE;
      cnt_d   = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) state_d = HI;
        end
        HI: begin
          if (fall) begin
            state_d  = LO;
            hi_tmp_d = cnt_inc;
          end else if (cnt_q == 32'(TIMEOUT - 1)) begin
            state_d     = IDLE;
            cnt_d       = 32'd0;
            set_timeout = 1'b1;
          end
        end
        LO: begin
          if (rise) begin
            state_d   = HI;
            high_d    = hi_tmp_q;
            period_d  = cnt_inc;
            set_valid = 1'b1;
            cnt_d     = 32'd0;
          end else if (cnt_q == 32'(TIMEOUT - 1)) begin
            state_d     = IDLE;
            cnt_d       = 32'd0;
            set_timeout = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 32'd0;
        end
      endcase
    end
  end

  assign set_ovf = (state_q != IDLE) && (cnt_d == 32'hFFFF_FFFF);

  always_comb begin
    ctrl_d   = ctrl_q;
    status_d = status_q;
    if (wr && bus.bus_addr == ADDR_CTRL) ctrl_d = bus.bus_write_data[0];
    if (wr && bus.bus_addr == ADDR_STATUS) status_d = status_q & ~bus.bus_write_data[2:0];
    status_d = status_d | {set_ovf, set_timeout, set_valid};
  end

  always_comb begin
    bus.bus_read_data = 32'd0;
    if (rd) begin
      case (bus.bus_addr)
        ADDR_CTRL:   bus.bus_read_data = {31'd0, ctrl_q};
        ADDR_STATUS: bus.bus_read_data = {29'd0, status_q};
        ADDR_HIGH:   bus.bus_read_data = high_q;
        ADDR_PERIOD: bus.bus_read_data = period_q;
        default:     bus.bus_read_data = 32'd0;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      lvl_q    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= 32'd0;
      hi_tmp_q <= 32'd0;
      high_q   <= 32'd0;
      period_q <= 32'd0;
      ctrl_q   <= 1'b0;
      status_q <= 3'd0;
    end else begin
      sync1_q  <= pwm_in;
      sync2_q  <= sync1_q;
      lvl_q    <= lvl;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_tmp_q <= hi_tmp_d;
      high_q   <= high_d;
      period_q <= period_d;
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
    end
  end

  assign capture_valid = status_q[0];

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;
  logic pclk = 1'b0;
  logic nreset;
  logic pwm_in;
  logic capture_valid;

  pwm_capture_if bus ();

  pwm_capture #(.TIMEOUT(1000), .FILTER_LEN(4)) dut (
    .pclk          (pclk),
    .nreset        (nreset),
    .bus           (bus),
    .pwm_in        (pwm_in),
    .capture_valid (capture_valid)
  );

  always #5 pclk = ~pclk;

`ifdef PWMCAP_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus.bus_read_en = 1'b1;
    bus.capture_en  = 1'b1;
    bus.bus_addr    = a;
    #1;
    d = bus.bus_read_data;
    bus.bus_read_en = 1'b0;
    bus.capture_en  = 1'b0;
    chk(tag, d, exp);
  endtask

  task automatic wr_start(input logic [7:0] a, input logic [31:0] d);
    bus.bus_write_en   = 1'b1;
    bus.capture_en     = 1'b1;
    bus.bus_addr       = a;
    bus.bus_write_data = d;
  endtask

  task automatic wr_end();
    bus.bus_write_en = 1'b0;
    bus.capture_en   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_start(a, d);
    tick();
    wr_end();
  endtask

  task automatic seg(input logic level, input int n);
    pwm_in = level;
    repeat (n) tick();
  endtask

  int exp_high, exp_period;
  int h, l;

  initial begin
    nreset             = 1'b0;
    pwm_in             = 1'b0;
    bus.bus_write_en   = 1'b0;
    bus.bus_read_en    = 1'b0;
    bus.capture_en     = 1'b0;
    bus.bus_addr       = 8'h00;
    bus.bus_write_data = 32'd0;
    repeat (3) tick();
    chk_reg("rst_ctrl", 8'h00, 0);
    chk_reg("rst_status", 8'h04, 0);
    chk_reg("rst_high", 8'h08, 0);
    chk_reg("rst_period", 8'h0C, 0);
    chk("rst_cv", {31'd0, capture_valid}, 0);
    nreset = 1'b1;
    tick();

    // Basic 150/1000 capture followed by a timeout
    wr(8'h00, 1);
    chk_reg("ctrl_rw", 8'h00, 1);
    chk_reg("unmapped", 8'h10, 0);
    seg(1'b1, 150);
    seg(1'b0, 850);
    seg(1'b1, LAT + 1);
    chk_reg("t1_high", 8'h08, 150);
    chk_reg("t1_period", 8'h0C, 1000);
    chk_reg("t1_status", 8'h04, 1);
    chk("t1_cv", {31'd0, capture_valid}, 1);
    seg(1'b1, 150 - LAT - 1);
    seg(1'b0, 1200);
    chk_reg("t2_status", 8'h04, 3);
    chk_reg("t2_high", 8'h08, 150);
    chk_reg("t2_period", 8'h0C, 1000);
    wr(8'h04, 2);
    chk_reg("t2_w1c", 8'h04, 1);
    wr(8'h08, 32'h1234);
    chk_reg("ro_high", 8'h08, 150);

    // W1C colliding with the capture edge, then one cycle later
    seg(1'b1, 200);
    seg(1'b0, 700);
    seg(1'b1, LAT - 1);
    wr_start(8'h04, 1);
    tick();
    wr_end();
    chk_reg("t3_set_wins", 8'h04, 1);
    wr(8'h04, 1);
    chk_reg("t3_cleared", 8'h04, 0);
    chk("t3_cv", {31'd0, capture_valid}, 0);
    chk_reg("t3_high", 8'h08, 200);
    chk_reg("t3_period", 8'h0C, 900);
    seg(1'b1, 100);
    wr(8'h00, 0);
    seg(1'b0, 20);

    // Randomized periods against the cycle-count model
    wr(8'h04, 7);
    wr(8'h00, 1);
    seg(1'b0, 10);
    for (int i = 0; i < 9; i++) begin
      h = $urandom_range(20, 300);
      l = $urandom_range(20, 300);
      seg(1'b1, LAT + 1);
      if (i > 0) begin
        chk_reg("rnd_high", 8'h08, exp_high);
        chk_reg("rnd_period", 8'h0C, exp_period);
        chk_reg("rnd_status", 8'h04, 1);
      end
      seg(1'b1, h - LAT - 1);
      seg(1'b0, l);
      exp_high   = h;
      exp_period = h + l;
    end

    // Enable in the middle of a high pulse
    wr(8'h00, 0);
    wr(8'h04, 7);
    seg(1'b1, 30);
    wr(8'h00, 1);
    seg(1'b1, 100);
    seg(1'b0, 400);
    seg(1'b1, LAT + 1);
    chk_reg("t4_no_partial", 8'h04, 0);
    seg(1'b1, 120 - LAT - 1);
    seg(1'b0, 400);
    seg(1'b1, LAT + 1);
    chk_reg("t4_high", 8'h08, 120);
    chk_reg("t4_period", 8'h0C, 520);
    chk_reg("t4_status", 8'h04, 1);

    // Reset in the middle of a high pulse
    seg(1'b1, 50);
    nreset = 1'b0;
    #1;
    chk_reg("t5_ctrl", 8'h00, 0);
    chk_reg("t5_status", 8'h04, 0);
    chk_reg("t5_high", 8'h08, 0);
    chk_reg("t5_period", 8'h0C, 0);
    chk("t5_cv", {31'd0, capture_valid}, 0);
    tick();
    nreset = 1'b1;
    tick();
    seg(1'b0, 300);
    seg(1'b1, 100);
    seg(1'b0, 300);
    seg(1'b1, 100);
    seg(1'b0, 20);
    chk_reg("t5_no_cap_status", 8'h04, 0);
    chk_reg("t5_no_cap_high", 8'h08, 0);
    chk_reg("t5_ctrl_after", 8'h00, 0);

    // Short low glitch inside a 150-cycle pulse
    wr(8'h00, 1);
    seg(1'b0, 20);
    seg(1'b1, 70);
    seg(1'b0, 2);
    seg(1'b1, 78);
    seg(1'b0, 850);
    seg(1'b1, LAT + 1);
`ifdef PWMCAP_FILTER_EN
    chk_reg("t6_high", 8'h08, 150);
    chk_reg("t6_period", 8'h0C, 1000);
`else
    chk_reg("t6_high", 8'h08, 78);
    chk_reg("t6_period", 8'h0C, 928);
`endif
    seg(1'b1, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
